// File: rtl/west_feeder_pkg.sv
// -----------------------------------------------------------------------------
// west_feeder_pkg
//   Shared definitions for the west-edge feeder of the systolic array.
//   - INST_* : 2-bit per-row instruction codes carried alongside each data slot
//              (bit1 = execute, bit0 = load / output-trigger).
//   - state_t: controller state encoding.
//   - cnt_inc: saturating 8-bit increment used by the phase counters.
// -----------------------------------------------------------------------------
package west_feeder_pkg;

    localparam logic [1:0] INST_IDLE = 2'b00;
    localparam logic [1:0] INST_LOAD = 2'b01;
    localparam logic [1:0] INST_EXEC = 2'b10;

    localparam int CNT_W = 8;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_EXEC  = 3'd2,
        ST_TRIG  = 3'd3,
        ST_DRAIN = 3'd4,
        ST_DONE  = 3'd5
    } state_t;

    // Phase counters never wrap: they hold at all-ones instead.
    function automatic logic [CNT_W-1:0] cnt_inc(input logic [CNT_W-1:0] c);
        return (c == {CNT_W{1'b1}}) ? c : c + {{(CNT_W-1){1'b0}}, 1'b1};
    endfunction

endpackage

// File: rtl/skew_delay.sv
// -----------------------------------------------------------------------------
// skew_delay
//   Registered shift line of `depth` stages, `width` bits wide. Used once per
//   array row to produce the diagonal skew of the west-edge feed.
//
//   Ports:
//     clk   : clock, rising edge
//     reset : synchronous active-high; clears every stage to zero
//     din   : slot entering stage 0
//     dout  : slot leaving the last stage (depth cycles after entry)
// -----------------------------------------------------------------------------
module skew_delay #(
    parameter int depth = 1,
    parameter int width = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [width-1:0] din,
    output logic [width-1:0] dout
);

    logic [depth-1:0][width-1:0] stage_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            stage_reg <= '0;
        end else begin
            stage_reg[0] <= din;
            for (int i = 1; i < depth; i++) begin
                stage_reg[i] <= stage_reg[i-1];
            end
        end
    end

    assign dout = stage_reg[depth-1];

endmodule

// File: rtl/west_feeder.sv
// -----------------------------------------------------------------------------
// west_feeder
//   Feeds the west edge of a row x col systolic array. A run optionally loads
//   `col` weight vectors (weight-stationary), then streams `len` execute
//   vectors, then (output-stationary only) issues one output-trigger slot, and
//   finally drains the skew lines so every row is idle when `done` pulses.
//
//   Each cycle produces one stage-0 slot {data, inst}. Row r sees that slot
//   r+1 cycles later through its own skew_delay, so data and instruction
//   always travel together and stalls appear as whole bubbles on every row.
//
//   Ports:
//     clk, reset   : clock and synchronous active-high reset
//     start        : run request, honoured only while idle
//     mode_select  : 0 = weight-stationary, 1 = output-stationary (on start)
//     len          : execute vectors for the run (on start), 0 allowed
//     in_data      : source vector, row r in [r*bw +: bw]
//     in_valid     : source valid
//     in_ready     : feeder can accept a vector this cycle
//     out_w        : skewed per-row data, row r in [r*bw +: bw]
//     inst_w       : skewed per-row instruction, row r in [r*2 +: 2]
//     busy         : a run is in progress
//     done         : one-cycle pulse at the end of a run
// -----------------------------------------------------------------------------
module west_feeder
    import west_feeder_pkg::*;
#(
    parameter int row = 8,
    parameter int col = 8,
    parameter int bw  = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              mode_select,
    input  logic [7:0]        len,
    input  logic [row*bw-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [row*bw-1:0] out_w,
    output logic [row*2-1:0]  inst_w,
    output logic              busy,
    output logic              done
);

    localparam logic [CNT_W-1:0] COL_LIMIT  = CNT_W'(col);
    localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(row - 1);

    // ------------------------------------------------------------------
    // Controller state
    // ------------------------------------------------------------------
    state_t           state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg,   cnt_next;
    logic [CNT_W-1:0] len_reg,   len_next;
    logic             mode_reg,  mode_next;

    logic [CNT_W-1:0] cnt_plus;
    logic [CNT_W-1:0] phase_limit;
    logic             exhausted;
    logic             ready_int;
    logic             xfer;
    logic [1:0]       slot_inst;

    assign cnt_plus    = cnt_inc(cnt_reg);
    assign phase_limit = (state_reg == ST_LOAD) ? COL_LIMIT : len_reg;
    assign exhausted   = (cnt_reg >= phase_limit);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= ST_IDLE;
            cnt_reg   <= '0;
            len_reg   <= '0;
            mode_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            len_reg   <= len_next;
            mode_reg  <= mode_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        len_next   = len_reg;
        mode_next  = mode_reg;
        ready_int  = 1'b0;
        xfer       = 1'b0;
        slot_inst  = INST_IDLE;

        case (state_reg)
            ST_IDLE: begin
                if (start) begin
                    mode_next  = mode_select;
                    len_next   = len;
                    cnt_next   = '0;
                    state_next = mode_select ? ST_EXEC : ST_LOAD;
                end
            end

            ST_LOAD, ST_EXEC: begin
                ready_int = !exhausted;
                xfer      = ready_int && in_valid;
                if (xfer) begin
                    slot_inst = (state_reg == ST_LOAD) ? INST_LOAD : INST_EXEC;
                    cnt_next  = cnt_plus;
                end
                // Leave on the final transfer itself so the phases abut with
                // no bubble; an already-empty phase (len = 0) leaves after
                // one idle cycle.
                if (exhausted || (xfer && (cnt_plus >= phase_limit))) begin
                    cnt_next = '0;
                    if (state_reg == ST_LOAD) begin
                        state_next = ST_EXEC;
                    end else begin
                        state_next = mode_reg ? ST_TRIG : ST_DRAIN;
                    end
                end
            end

            ST_TRIG: begin
                slot_inst  = INST_LOAD;
                cnt_next   = '0;
                state_next = ST_DRAIN;
            end

            ST_DRAIN: begin
                // Pushes idle slots for row cycles so the deepest skew line
                // is empty by the time done is raised.
                if (cnt_reg >= DRAIN_LAST) begin
                    cnt_next   = '0;
                    state_next = ST_DONE;
                end else begin
                    cnt_next = cnt_plus;
                end
            end

            ST_DONE: begin
                state_next = ST_IDLE;
            end

            default: begin
                state_next = ST_IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    // Outputs are forced low for the whole time reset is held, including the
    // cycle before the first clock edge under reset.
    assign in_ready = ready_int && !reset;
    assign busy     = (state_reg != ST_IDLE) && !reset;
    assign done     = (state_reg == ST_DONE) && !reset;

    // ------------------------------------------------------------------
    // Per-row skew lines: row gi delays the shared stage-0 slot gi+1 cycles
    // ------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < row; gi++) begin : g_row
            logic [bw+1:0] row_din;
            logic [bw+1:0] row_dout;

            // Data is zeroed on every non-transfer slot (stall, TRIG, drain).
            assign row_din = {xfer ? in_data[gi*bw +: bw] : {bw{1'b0}}, slot_inst};

            skew_delay #(
                .depth (gi + 1),
                .width (bw + 2)
            ) u_skew (
                .clk   (clk),
                .reset (reset),
                .din   (row_din),
                .dout  (row_dout)
            );

            assign out_w [gi*bw +: bw] = reset ? {bw{1'b0}} : row_dout[bw+1:2];
            assign inst_w[gi*2  +: 2]  = reset ? 2'b00      : row_dout[1:0];
        end
    endgenerate

endmodule

// File: doc/west_feeder.md
WEST_FEEDER -- requirements
Module: west_feeder

Interface
REQ-001 Parameters SHALL be: row, default 8, number of array rows fed; col, default 8, number of array columns, which is also the weight vectors per kernel load; bw, default 4, activation/weight width.
REQ-002 clk  input  1  clock, all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 start  input  1  single-cycle pulse, accepted only in IDLE.
REQ-005 mode_select  input  1  0 = weight-stationary (WS), 1 = output-stationary (OS); sampled on accepted start.
REQ-006 len  input  8  execute vectors per run, sampled on accepted start; 0 is legal.
REQ-007 in_data  input  row*bw  source vector, row r in bits [r*bw +: bw].
REQ-008 in_valid  input  1 / in_ready  output  1  valid/ready handshake; transfer when both high.
REQ-009 out_w  output  row*bw  per-row data to array west edge, row r in [r*bw +: bw].
REQ-010 inst_w  output  row*2  per-row instruction, row r in [r*2 +: 2]; bit1 execute, bit0 load/output-trigger.
REQ-011 busy  output  1  high in every state except IDLE.
REQ-012 done  output  1  one-cycle pulse on DONE.

Function
REQ-013 FSM states SHALL be IDLE, LOAD, EXEC, TRIG, DRAIN, DONE.
REQ-014 Transitions: IDLE->LOAD on start with mode 0; IDLE->EXEC on start with mode 1; LOAD->EXEC after col transfers; EXEC->DRAIN (WS) or ->TRIG (OS) after len transfers; TRIG->DRAIN after 1 cycle; DRAIN->DONE after row cycles; DONE->IDLE after 1 cycle.
REQ-015 len=0: EXEC exits on the next cycle with no transfers.
REQ-016 in_ready SHALL be high only in LOAD and EXEC while the phase count is not exhausted.
REQ-017 Stage-0 slot per cycle: LOAD transfer -> {in_data, 2'b01}; EXEC transfer -> {in_data, 2'b10}; TRIG -> {0, 2'b01}; any other cycle, including a stall with in_valid low -> {0, 2'b00}.
REQ-018 Row 0 SHALL present the stage-0 slot 1 cycle after the handshake; row r SHALL present the same slot r+1 cycles after the handshake (diagonal skew).
REQ-019 Data and instruction of a slot SHALL travel together, and no slot SHALL be dropped or duplicated.
REQ-020 Stalls SHALL insert whole 00 bubbles into every row's sequence with identical skew.
REQ-021 DRAIN SHALL inject 00 slots for row cycles, so all rows are idle when done fires.
REQ-022 start while busy SHALL be ignored.
REQ-023 Phase counters SHALL be 8 bits with no wrap; the LOAD count compares against col.

Reset
REQ-024 On reset the state SHALL go to IDLE, with all counters 0 and all skew stages {0, 00}.
REQ-025 While in reset, the outputs SHALL be: out_w = 0, inst_w = 0, in_ready = 0, busy = 0, done = 0.
REQ-026 Reset mid-run SHALL abort the run and discard any in-flight skew slots.

Structure
REQ-027 A shared package SHALL hold the INST_IDLE=2'b00, INST_LOAD=2'b01 and INST_EXEC=2'b10 constants and the state encoding.
REQ-028 One sub-module, skew_delay (parameters depth, width; registered shift line of depth stages), SHALL be instantiated per row with depth = r+1.

Verification
REQ-029 WS, row=col=4, len=2, in_valid always high: 4 LOAD then 2 EXEC transfers. Row 0 inst_w shows 01,01,01,01,10,10 starting at cycle t+1. Row 3 shows the same sequence starting at t+4. done fires after DRAIN.
REQ-030 OS, len=3: no LOAD phase. Each row's sequence is 10,10,10,01 followed by 00. in_ready is never high outside EXEC.
REQ-031 Stall: WS, in_valid low for 2 cycles after the 2nd load vector. Each row shows 01,01,00,00,01,01 with identical skew, and exactly 4 load slots reach every row.
REQ-032 len=0, mode 1: the sequence is a TRIG slot only. done fires row+3 cycles after start, with no in_ready assertion.
REQ-033 Reset asserted during EXEC with slots in flight: the next cycle shows inst_w=0, out_w=0 and IDLE. A new start then runs cleanly.
REQ-034 start pulsed while busy: no effect on sequence or counts. Data check: in_data row2=4'hA in an EXEC transfer appears on out_w row 2 exactly 3 cycles later.
